wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter that drives the register file's write port. It merges two result sources into the single write port (write, WR, WD): the in-order pipeline writeback path, and a long-latency multicycle unit (multiply/divide/load miss) delivered over a valid/ready handshake. Multicycle results are buffered in a small FIFO. Writes to r0 are dropped. A starvation counter guarantees that buffered results eventually retire, by stalling the pipeline path when needed.

## Interface
Parameters:
- DEPTH, 2: multicycle FIFO entries; power of two, ≥2.
- STARVE_LIMIT, 4: consecutive cycles the FIFO head may lose arbitration before pipe_stall asserts; range 1..15.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- pipe_write  in  1  pipeline writeback request this cycle.
- pipe_WR  in  5  pipeline destination register.
- pipe_WD  in  32  pipeline write data.
- pipe_stall  out  1  pipeline request is not accepted this cycle; upstream holds pipe_* stable.
- mc_valid  in  1  multicycle result offered.
- mc_ready  out  1  FIFO can accept; transfer occurs when mc_valid && mc_ready at a rising edge.
- mc_WR  in  5  multicycle destination register.
- mc_WD  in  32  multicycle data.
- mc_pending  out  1  FIFO non-empty; issue logic uses it for hazard stalls.
- write  out  1  register-file write enable (registered).
- WR  out  5  register-file write address (registered).
- WD  out  32  register-file write data (registered).

## Operation
- Reset values: write=0, WR=0, WD=0, FIFO empty, starve counter=0. Consequently mc_ready=1, mc_pending=0, pipe_stall=0.
- mc_ready = (count < DEPTH). It is derived only from registered state and never depends on mc_valid or on a same-cycle pop. A full FIFO therefore refuses a push even in a cycle where it pops.
- A handshaken result with mc_WR=0 is accepted (consumes the handshake) but is not enqueued.
- Arbitration each cycle, evaluated in order:
  1. pipe_stall=1 and FIFO non-empty: pop the head and write it. The pipeline request waits.
  2. pipe_write=1 and pipe_WR≠0: write the pipeline request.
  3. FIFO non-empty: pop the head and write it.
  4. Otherwise: write=0 next cycle.
- A pipeline request with pipe_WR=0 and pipe_stall=0 is consumed with no write. Rules 3–4 then apply in that cycle.
- Starve counter:
  - Increments when the FIFO is non-empty and rule 2 wins.
  - Clears on any FIFO pop and whenever the FIFO is empty.
  - pipe_stall = (counter ≥ STARVE_LIMIT) && FIFO non-empty, decoded from registered state.
- FIFO is strictly in order. Pointers are log2(DEPTH) bits wrapping modulo DEPTH. count is log2(DEPTH)+1 bits.
- Simultaneous push and pop on a non-full FIFO: count is unchanged and the pointers both advance. A push into an empty FIFO cannot be popped in the same cycle; no pass-through.
- The block performs no WAW or RAW checking between sources. The issue logic must not issue to a register that has a multicycle write outstanding.
- Reset mid-operation discards all FIFO contents and any pending output write immediately (asynchronous). Lost multicycle results are the owner's responsibility.

## Timing
- Pipeline path: request in cycle N produces write/WR/WD in cycle N+1. The register file commits at the end of cycle N+1.
- Multicycle path, minimum latency: handshake at edge ending cycle N puts the entry at the FIFO head in cycle N+1, and write appears in cycle N+2.
- Throughput is one register-file write per cycle. The FIFO sustains one push and one pop per cycle.
- Worst-case wait for the FIFO head is STARVE_LIMIT cycles plus 1.
- write deasserts in the cycle after the last selected request. Outputs never glitch mid-cycle because they are flops.

## Test plan
- Reset then idle: assert reset asynchronously mid-cycle → write=0, WR=0, WD=0, mc_ready=1, mc_pending=0, pipe_stall=0 before the next edge.
- Pipe only: pipe_write=1, pipe_WR=5, pipe_WD=0xDEADBEEF in cycle 3 → write=1, WR=5, WD=0xDEADBEEF in cycle 4 only. pipe_WR=0 → write stays 0.
- MC fill/drain: with pipe_write held at 1 to r1–r3, push r7=0x11 then r8=0x22 → mc_ready=0 after 2 pushes and a third offer is held off. After the pipe stops, writes r7=0x11 then r8=0x22 in order on consecutive cycles, with mc_pending falling with the last pop.
- Starvation (STARVE_LIMIT=4): one FIFO entry r9=0x33, pipe_write=1 every cycle → 4 pipe writes, then pipe_stall=1 for one cycle, r9=0x33 written, and the pipe write resumes with its held values.
- Simultaneous events:
  - Push and pop at count=1 → count stays 1 and FIFO order is preserved across pointer wrap over 10 transactions.
  - Push while full with a pop → refused.
- Reset mid-drain with 2 entries queued → no further writes, and the FIFO is empty after release.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: pipeline, multicycle and register-file write signals of the writeback arbiter
interface wb_arbiter_if;
    logic        pipe_write;
    logic [4:0]  pipe_WR;
    logic [31:0] pipe_WD;
    logic        pipe_stall;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_WR;
    logic [31:0] mc_WD;
    logic        mc_pending;
    logic        write;
    logic [4:0]  WR;
    logic [31:0] WD;
    modport slave (
        input  pipe_write, pipe_WR, pipe_WD, mc_valid, mc_WR, mc_WD,
        output pipe_stall, mc_ready, mc_pending, write, WR, WD
    );
    modport master (
        output pipe_write, pipe_WR, pipe_WD, mc_valid, mc_WR, mc_WD,
        input  pipe_stall, mc_ready, mc_pending, write, WR, WD
    );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges pipeline writeback and buffered multicycle results onto one register-file write port
module wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic        clk,
    input logic        reset,
    wb_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [36:0]   mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic [3:0]    starve;
    logic          empty, pipe_ok, push, pop;
    logic [36:0]   head;
    // arbitration: a starved head preempts the pipe, otherwise a valid pipe write wins over the FIFO
    always_comb begin
        empty          = count == '0;
        head           = mem[rptr];
        bus.mc_ready   = count < FULL;
        bus.mc_pending = !empty;
        bus.pipe_stall = starve >= LIMIT && !empty;
        pipe_ok        = bus.pipe_write && bus.pipe_WR != '0 && !bus.pipe_stall;
        pop            = !empty && !pipe_ok;
        push           = bus.mc_valid && bus.mc_ready && bus.mc_WR != '0;
    end
    // FIFO storage needs no reset; only pointers and count define validity
    always_ff @(posedge clk)
        if (push) mem[wptr] <= {bus.mc_WR, bus.mc_WD};
    // pointers, occupancy, starvation counter and registered write port
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            starve    <= '0;
            bus.write <= 1'b0;
            bus.WR    <= '0;
            bus.WD    <= '0;
        end else begin
            wptr      <= wptr + AW'(push);
            rptr      <= rptr + AW'(pop);
            count     <= count + (AW+1)'(push) - (AW+1)'(pop);
            starve    <= (empty || pop) ? '0 : starve + 4'(pipe_ok);
            bus.write <= pipe_ok || pop;
            {bus.WR, bus.WD} <= pipe_ok ? {bus.pipe_WR, bus.pipe_WD} : head;
        end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter
module tb_wb_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    wb_arbiter_if bus();
    wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk_wr(input string name, input logic w, input logic [4:0] r, input logic [31:0] d);
        checks++;
        if (bus.write !== w || (w && (bus.WR !== r || bus.WD !== d))) begin
            errors++;
            $display("FAIL %s: got write=%b WR=%0d WD=%h, want write=%b WR=%0d WD=%h",
                     name, bus.write, bus.WR, bus.WD, w, r, d);
        end
    endtask
    task automatic chk_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask
    task automatic fill_two(input logic [4:0] r0, input logic [31:0] d0, input logic [4:0] r1, input logic [31:0] d1);
        bus.pipe_write = 1; bus.pipe_WR = 4; bus.pipe_WD = 32'h4;
        bus.mc_valid = 1; bus.mc_WR = r0; bus.mc_WD = d0;
        tick();
        bus.mc_WR = r1; bus.mc_WD = d1;
        tick();
        bus.mc_valid = 0;
    endtask
    task automatic test_reset();
        bus.pipe_write = 1; bus.pipe_WR = 3; bus.pipe_WD = 32'h1234;
        bus.mc_valid = 1; bus.mc_WR = 6; bus.mc_WD = 32'h66;
        reset = 0;
        tick();
        bus.mc_valid = 0;
        #2;
        reset = 1;
        #1;
        checks++;
        if (bus.write !== 0 || bus.WR !== 0 || bus.WD !== 0) begin
            errors++;
            $display("FAIL reset_out: got write=%b WR=%0d WD=%h want 0/0/0", bus.write, bus.WR, bus.WD);
        end
        chk_bit("reset_mc_ready", bus.mc_ready, 1'b1);
        chk_bit("reset_mc_pending", bus.mc_pending, 1'b0);
        chk_bit("reset_pipe_stall", bus.pipe_stall, 1'b0);
        bus.pipe_write = 0;
        tick();
        reset = 0;
        tick();
        chk_wr("idle", 0, 0, 0);
    endtask
    task automatic test_pipe();
        bus.pipe_write = 1; bus.pipe_WR = 5; bus.pipe_WD = 32'hDEADBEEF;
        tick();
        chk_wr("pipe_write", 1, 5, 32'hDEADBEEF);
        bus.pipe_write = 0;
        tick();
        chk_wr("pipe_deassert", 0, 0, 0);
        bus.pipe_write = 1; bus.pipe_WR = 0; bus.pipe_WD = 32'h55;
        tick();
        chk_wr("pipe_r0", 0, 0, 0);
        bus.pipe_write = 0;
        bus.mc_valid = 1; bus.mc_WR = 0; bus.mc_WD = 32'h77;
        tick();
        bus.mc_valid = 0;
        chk_bit("mc_r0_dropped", bus.mc_pending, 1'b0);
        tick();
        chk_wr("mc_r0_nowrite", 0, 0, 0);
    endtask
    task automatic test_fill_drain();
        bus.pipe_write = 1; bus.pipe_WR = 1; bus.pipe_WD = 32'h1;
        bus.mc_valid = 1; bus.mc_WR = 7; bus.mc_WD = 32'h11;
        tick();
        chk_wr("fill_pipe_r1", 1, 1, 32'h1);
        chk_bit("fill_pending1", bus.mc_pending, 1'b1);
        chk_bit("fill_ready1", bus.mc_ready, 1'b1);
        bus.pipe_WR = 2; bus.pipe_WD = 32'h2;
        bus.mc_WR = 8; bus.mc_WD = 32'h22;
        tick();
        chk_wr("fill_pipe_r2", 1, 2, 32'h2);
        chk_bit("fill_ready_full", bus.mc_ready, 1'b0);
        bus.pipe_WR = 3; bus.pipe_WD = 32'h3;
        bus.mc_WR = 9; bus.mc_WD = 32'h99;
        tick();
        chk_wr("fill_pipe_r3", 1, 3, 32'h3);
        chk_bit("fill_third_held", bus.mc_ready, 1'b0);
        bus.pipe_write = 0; bus.mc_valid = 0;
        tick();
        chk_wr("drain_r7", 1, 7, 32'h11);
        chk_bit("drain_pending_mid", bus.mc_pending, 1'b1);
        tick();
        chk_wr("drain_r8", 1, 8, 32'h22);
        chk_bit("drain_pending_end", bus.mc_pending, 1'b0);
        tick();
        chk_wr("drain_idle", 0, 0, 0);
    endtask
    task automatic test_starve();
        bus.pipe_write = 1; bus.pipe_WR = 10; bus.pipe_WD = 32'hA;
        bus.mc_valid = 1; bus.mc_WR = 9; bus.mc_WD = 32'h33;
        tick();
        bus.mc_valid = 0;
        chk_wr("starve_pre", 1, 10, 32'hA);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_wr($sformatf("starve_pipe%0d", i), 1, 10, 32'hA);
            chk_bit($sformatf("starve_stall%0d", i), bus.pipe_stall, i == 3);
        end
        tick();
        chk_wr("starve_pop_r9", 1, 9, 32'h33);
        chk_bit("starve_stall_clear", bus.pipe_stall, 1'b0);
        chk_bit("starve_empty", bus.mc_pending, 1'b0);
        tick();
        chk_wr("starve_resume", 1, 10, 32'hA);
        bus.pipe_write = 0;
        tick();
        chk_wr("starve_idle", 0, 0, 0);
    endtask
    task automatic test_back_to_back();
        bus.mc_valid = 1; bus.mc_WR = 1; bus.mc_WD = 32'h100;
        tick();
        for (int i = 1; i <= 10; i++) begin
            bus.mc_WR = 5'(i + 1); bus.mc_WD = 32'h100 + 32'(i);
            tick();
            chk_wr($sformatf("b2b_pop%0d", i), 1, 5'(i), 32'h100 + 32'(i - 1));
            chk_bit($sformatf("b2b_pending%0d", i), bus.mc_pending, 1'b1);
            chk_bit($sformatf("b2b_ready%0d", i), bus.mc_ready, 1'b1);
        end
        bus.mc_valid = 0;
        tick();
        chk_wr("b2b_last", 1, 11, 32'h10A);
        tick();
        chk_wr("b2b_idle", 0, 0, 0);
    endtask
    task automatic test_full_pop();
        fill_two(12, 32'hC, 13, 32'hD);
        bus.pipe_write = 0;
        bus.mc_valid = 1; bus.mc_WR = 14; bus.mc_WD = 32'hE;
        chk_bit("full_ready", bus.mc_ready, 1'b0);
        tick();
        bus.mc_valid = 0;
        chk_wr("full_pop_r12", 1, 12, 32'hC);
        chk_bit("full_ready_after", bus.mc_ready, 1'b1);
        tick();
        chk_wr("full_pop_r13", 1, 13, 32'hD);
        tick();
        chk_wr("full_refused", 0, 0, 0);
        chk_bit("full_refused_empty", bus.mc_pending, 1'b0);
    endtask
    task automatic test_reset_drain();
        fill_two(20, 32'h14, 21, 32'h15);
        bus.pipe_write = 0;
        chk_bit("rd_pending", bus.mc_pending, 1'b1);
        #2;
        reset = 1;
        #1;
        chk_wr("rd_async", 0, 0, 0);
        chk_bit("rd_async_empty", bus.mc_pending, 1'b0);
        tick();
        reset = 0;
        tick();
        chk_wr("rd_after1", 0, 0, 0);
        tick();
        chk_wr("rd_after2", 0, 0, 0);
        chk_bit("rd_empty", bus.mc_pending, 1'b0);
        chk_bit("rd_ready", bus.mc_ready, 1'b1);
    endtask
    initial begin
        bus.pipe_write = 0; bus.pipe_WR = 0; bus.pipe_WD = 0;
        bus.mc_valid = 0; bus.mc_WR = 0; bus.mc_WD = 0;
        tick();
        test_reset();
        test_pipe();
        test_fill_drain();
        test_starve();
        test_back_to_back();
        test_full_pop();
        test_reset_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
